gray_conv_arbitro: RTL and testbench
====================================

Name: gray_conv_arbitro

Overview:
- Shares one 4-bit binary-to-Gray converter among N requesters.
- Round-robin arbitration picks one requester and captures its operand. The block converts it and presents the registered result with the requester's id on a valid/ready output.
- Sits between multiple BCD/binary producers and a single Gray-code consumer (display/encoder path).

Parameters:
- N, 4, number of requesters; legal range 2..16.
- LARGURA_CONT, 8, width of the completed-transfer counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester request; held high with operand stable until ack.
- entrada  input  4*N  operands; requester i uses bits [4i+3:4i].
- ack  output  N  one-cycle pulse to the requester whose operand was captured.
- saida  output  4  Gray-coded result.
- saida_id  output  max(1,$clog2(N))  index of the requester that owns saida.
- saida_valida  output  1  saida/saida_id valid.
- saida_pronta  input  1  downstream ready.
- ocupado  output  1  high in any state other than OCIOSO.
- total  output  LARGURA_CONT  count of completed output handshakes; wraps modulo 2^LARGURA_CONT.

Behaviour:
- Reset (rst high at a rising edge, overrides everything):
  - state OCIOSO, ack=0, saida=0, saida_id=0, saida_valida=0, total=0.
  - Round-robin pointer ptr=0.
  - An in-flight transaction is dropped: no ack, no output.
- Arbitration (combinational): winner = first i with req[i]=1, scanning ptr, ptr+1, ..., ptr+N-1 mod N.
- FSM states: OCIOSO, CONVERTE, ENTREGA.
- OCIOSO:
  - If any req: register winner into id_reg and entrada[winner] into op_reg, go CONVERTE.
  - Otherwise stay in OCIOSO.
- CONVERTE (exactly 1 cycle):
  - ack[id_reg]=1 this cycle only.
  - At the clock edge: saida<=gray(op_reg), saida_id<=id_reg, saida_valida<=1, go ENTREGA.
- ENTREGA:
  - saida, saida_id and saida_valida hold stable while saida_pronta=0 (no timeout).
  - On saida_valida & saida_pronta: total<=total+1 and ptr<=(id_reg+1) mod N.
  - Same edge, if any req present (arbitrated against the updated pointer, i.e. id_reg+1): capture the new winner and go CONVERTE; saida_valida<=0.
  - Same edge, if no req: saida_valida<=0, go OCIOSO.
- Latency:
  - req sampled in OCIOSO → ack 1 cycle later → saida_valida 2 cycles after the sample edge.
  - Back-to-back throughput with saida_pronta=1: one result per 2 cycles.
- Requester rules:
  - A requester deasserts req the cycle after seeing ack.
  - req still high in ENTREGA is treated as a new request with the current entrada value.
- Conversion: gray = b ^ (b>>1) on 4 bits. Values 0..15: 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8.
- req changes during CONVERTE/ENTREGA do not alter the captured op_reg/id_reg.
- ack is never asserted in OCIOSO or ENTREGA. At most one ack bit is high at any time.
- total wraps from 2^LARGURA_CONT-1 to 0 with no flag.
- Requesters with req=0 never receive ack. A requester held asserted is served within N transactions (no starvation).

Decomposition:
- Package gray_conv_pkg holds:
  - state enum {OCIOSO, CONVERTE, ENTREGA}.
  - function gray4(b) returning b^(b>>1).
  - constant ID_W = max(1,$clog2(N)) helper.
- One sub-module, bin_para_gray4: combinational 4-bit converter, instantiated once on op_reg. Arbitration and FSM stay in the top module.

Test Plan:
- Single request: reset, req=4'b0010, entrada[7:4]=5, saida_pronta=1. Required: ack=4'b0010 exactly one cycle; one cycle later saida=7, saida_id=1, saida_valida=1; total=1 after the handshake.
- Round-robin: all four req high with operands 3, 10, 12, 15, saida_pronta=1, each requester reissuing req immediately. Required: service order ids 0,1,2,3,0; saida 2,15,10,8; one result every 2 cycles.
- Backpressure: saida_pronta=0 for 5 cycles after saida_valida rises with operand 9. Required: saida=13 and saida_id held stable all 5 cycles, no new ack; completes on the first cycle saida_pronta=1.
- Reset mid-operation: assert rst during CONVERTE. Required next cycle: ack=0, saida_valida=0, saida=0, total=0, ptr=0, state OCIOSO.
- Exhaustive conversion plus counter wrap: requester 0 sends 0..15 repeatedly until 256 handshakes. Required: saida follows the Gray table for every value; total=255 after the 255th handshake, then 0 after the 256th.

Source files
------------

// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the shared Gray-code converter block.
// Holds the controller state encoding, the 4-bit binary-to-Gray function
// and the requester-index width helper used to size id ports.
package gray_conv_pkg;

  // Controller states: waiting for a request, converting the captured
  // operand, and presenting the result downstream.
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    ENTREGA  = 2'd2
  } estado_t;

  // Reflected binary code: each output bit is the xor of adjacent inputs.
  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bin_para_gray4.sv
// Combinational 4-bit binary to Gray-code converter.
// Ports: bin - binary operand in; gray - Gray-coded value out.
// Zero latency, no state.
module bin_para_gray4
  import gray_conv_pkg::*;
(
  input  logic [3:0] bin,
  output logic [3:0] gray
);

  assign gray = gray4(bin);

endmodule

// File: rtl/gray_conv_arbitro.sv
// One binary-to-Gray converter shared among N requesters via round-robin.
// Ports: clk/rst (sync, active high); req/entrada/ack toward the requesters;
//   saida/saida_id/saida_valida/saida_pronta toward the single consumer;
//   ocupado (not idle) and total (completed output handshakes, wrapping).
// Timing: request sampled in idle -> ack next cycle -> result valid the cycle
//   after; the result holds while saida_pronta is low.
module gray_conv_arbitro
  import gray_conv_pkg::*;
#(
  parameter int N            = 4,   // legal range 2..16
  parameter int LARGURA_CONT = 8,
  localparam int ID_W        = id_w(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  input  logic [4*N-1:0]          entrada,
  output logic [N-1:0]            ack,
  output logic [3:0]              saida,
  output logic [ID_W-1:0]         saida_id,
  output logic                    saida_valida,
  input  logic                    saida_pronta,
  output logic                    ocupado,
  output logic [LARGURA_CONT-1:0] total
);

  estado_t         estado, estado_prox;

  logic [ID_W-1:0] ptr;        // round-robin starting point
  logic [ID_W-1:0] id_reg;     // requester being served
  logic [3:0]      op_reg;     // its captured operand
  logic [3:0]      gray_op;

  logic [ID_W-1:0] id_seg;     // requester after id_reg, modulo N
  logic [ID_W-1:0] base;       // scan start for this cycle's arbitration
  logic [ID_W-1:0] idx;
  logic            venc_vld;
  logic [ID_W-1:0] venc_id;
  logic [3:0]      op_venc;

  logic            captura;    // load id_reg/op_reg at this edge
  logic            entrega_ok; // output handshake at this edge

  logic [3:0]      ops [N];

  // Unpack the flat operand bus so the winner can select by index.
  for (genvar g = 0; g < N; g++) begin : g_ops
    assign ops[g] = entrada[4*g +: 4];
  end

  assign id_seg = (id_reg == ID_W'(N-1)) ? '0 : id_reg + ID_W'(1);

  // When a handshake completes in ENTREGA the pointer moves to id_reg+1 at
  // the same edge, so the back-to-back capture must already scan from there.
  assign base = (estado == ENTREGA) ? id_seg : ptr;

  // Round-robin scan. Walking the offsets from last to first lets the
  // earliest requester in scan order overwrite any later one.
  always_comb begin
    venc_vld = 1'b0;
    venc_id  = '0;
    idx      = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = ID_W'((int'(base) + k) % N);
      if (req[idx]) begin
        venc_vld = 1'b1;
        venc_id  = idx;
      end
    end
  end

  assign op_venc = ops[venc_id];

  // Next-state and control decode.
  always_comb begin
    estado_prox = estado;
    captura     = 1'b0;
    entrega_ok  = 1'b0;
    ack         = '0;
    case (estado)
      OCIOSO: begin
        if (venc_vld) begin
          captura     = 1'b1;
          estado_prox = CONVERTE;
        end
      end
      CONVERTE: begin
        ack[id_reg] = 1'b1;
        estado_prox = ENTREGA;
      end
      ENTREGA: begin
        if (saida_valida && saida_pronta) begin
          entrega_ok = 1'b1;
          if (venc_vld) begin
            captura     = 1'b1;
            estado_prox = CONVERTE;
          end else begin
            estado_prox = OCIOSO;
          end
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  bin_para_gray4 u_conv (
    .bin  (op_reg),
    .gray (gray_op)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado       <= OCIOSO;
      ptr          <= '0;
      id_reg       <= '0;
      op_reg       <= '0;
      saida        <= '0;
      saida_id     <= '0;
      saida_valida <= 1'b0;
      total        <= '0;
    end else begin
      estado <= estado_prox;

      if (captura) begin
        id_reg <= venc_id;
        op_reg <= op_venc;
      end

      if (estado == CONVERTE) begin
        saida        <= gray_op;
        saida_id     <= id_reg;
        saida_valida <= 1'b1;
      end

      if (entrega_ok) begin
        saida_valida <= 1'b0;
        total        <= total + LARGURA_CONT'(1);
        ptr          <= id_seg;
      end
    end
  end

  assign ocupado = (estado != OCIOSO);

endmodule

// File: tb/tb_gray_conv_arbitro.sv
module tb_gray_conv_arbitro;

  localparam int N  = 4;
  localparam int LC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [4*N-1:0] entrada = '0;
  logic          saida_pronta = 1'b0;
  logic [N-1:0]  ack;
  logic [3:0]    saida;
  logic [1:0]    saida_id;
  logic          saida_valida;
  logic          ocupado;
  logic [LC-1:0] total;

  gray_conv_arbitro #(.N(N), .LARGURA_CONT(LC)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .entrada      (entrada),
    .ack          (ack),
    .saida        (saida),
    .saida_id     (saida_id),
    .saida_valida (saida_valida),
    .saida_pronta (saida_pronta),
    .ocupado      (ocupado),
    .total        (total)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int gray_tab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  // Transaction-level reference: one outstanding job at most, pointer is the
  // last served id plus one, results retire on valid & ready.
  int q_id[$], q_g[$];
  int log_id[$], log_g[$], log_cyc[$];
  bit outstanding = 0;
  bit m_valida    = 0;
  int m_total     = 0;
  int m_ptr       = 0;
  int hs_count    = 0;
  int cyc         = 0;
  logic [N-1:0]   cap_req;
  logic [4*N-1:0] cap_ent;
  logic           cap_rst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input int v);
    entrada[4*i +: 4] = 4'(v);
  endtask

  // Advance one clock: account for what the coming edge does, then sample
  // the DUT on the falling edge and compare against the reference.
  task automatic tick();
    bit capt;
    int w;
    int op;
    if (rst) begin
      outstanding = 0;
      q_id.delete();
      q_g.delete();
      m_total = 0;
      m_ptr   = 0;
    end else if (m_valida && saida_pronta && q_id.size() > 0) begin
      log_id.push_back(q_id[0]);
      log_g.push_back(q_g[0]);
      log_cyc.push_back(cyc);
      m_ptr   = (q_id[0] + 1) % N;
      m_total = (m_total + 1) % (1 << LC);
      void'(q_id.pop_front());
      void'(q_g.pop_front());
      outstanding = 0;
      hs_count++;
    end
    cap_req = req;
    cap_ent = entrada;
    cap_rst = rst;
    @(negedge clk);
    cyc++;
    capt = 0;
    w    = 0;
    if (!cap_rst && !outstanding && cap_req != '0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!capt && cap_req[j]) begin
          capt = 1;
          w    = j;
        end
      end
    end
    if (capt) begin
      op = int'((cap_ent >> (4*w)) & 16'hF);
      q_id.push_back(w);
      q_g.push_back(gray_tab[op]);
      outstanding = 1;
      m_valida    = 0;
    end else begin
      m_valida = outstanding;
    end
    chk("ack", 32'(ack), capt ? (32'd1 << w) : 32'd0);
    chk("saida_valida", 32'(saida_valida), 32'(m_valida));
    chk("ocupado", 32'(ocupado), 32'(outstanding));
    chk("total", 32'(total), 32'(m_total));
    if (m_valida && q_id.size() > 0) begin
      chk("saida", 32'(saida), 32'(q_g[0]));
      chk("saida_id", 32'(saida_id), 32'(q_id[0]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int op;
    int guard;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_saida", 32'(saida), 32'd0);
    chk("rst_saida_id", 32'(saida_id), 32'd0);
    rst = 1'b0;
    tick();

    // Single request from requester 1 with operand 5
    req = 4'b0010;
    set_op(1, 5);
    saida_pronta = 1'b1;
    tick();
    chk("single_ack", 32'(ack), 32'b0010);
    req = '0;
    tick();
    chk("single_ack_gone", 32'(ack), 32'd0);
    chk("single_valida", 32'(saida_valida), 32'd1);
    chk("single_saida", 32'(saida), 32'd7);
    chk("single_id", 32'(saida_id), 32'd1);
    tick();
    chk("single_total", 32'(total), 32'd1);
    tick();

    // Round-robin with all four requesters holding their requests
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(0, 3); set_op(1, 10); set_op(2, 12); set_op(3, 15);
    req = 4'b1111;
    saida_pronta = 1'b1;
    log_id.delete(); log_g.delete(); log_cyc.delete();
    for (int i = 0; i < 12; i++) tick();
    chk("rr_count", 32'(log_id.size() >= 5), 32'd1);
    if (log_id.size() >= 5) begin
      int exp_id [5] = '{0, 1, 2, 3, 0};
      int exp_g  [5] = '{2, 15, 10, 8, 2};
      for (int i = 0; i < 5; i++) begin
        chk("rr_id", 32'(log_id[i]), 32'(exp_id[i]));
        chk("rr_gray", 32'(log_g[i]), 32'(exp_g[i]));
        if (i > 0) chk("rr_spacing", 32'(log_cyc[i] - log_cyc[i-1]), 32'd2);
      end
    end
    req = '0;
    for (int i = 0; i < 4; i++) tick();

    // Backpressure on operand 9 from requester 2
    saida_pronta = 1'b0;
    req = 4'b0100;
    set_op(2, 9);
    guard = 0;
    do begin
      tick();
      if (ack[2]) req[2] = 1'b0;
      guard++;
    end while (!saida_valida && guard < 10);
    chk("bp_valid_seen", 32'(saida_valida), 32'd1);
    op = int'(total);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_saida", 32'(saida), 32'd13);
      chk("bp_id", 32'(saida_id), 32'd2);
      chk("bp_no_ack", 32'(ack), 32'd0);
    end
    saida_pronta = 1'b1;
    tick();
    chk("bp_done_valida", 32'(saida_valida), 32'd0);
    chk("bp_done_total", 32'(total), 32'((op + 1) % 256));
    tick();

    // Reset during CONVERTE
    req = 4'b0001;
    set_op(0, 6);
    tick();
    chk("mid_ack", 32'(ack), 32'd1);
    req = '0;
    rst = 1'b1;
    tick();
    chk("mid_ack_clr", 32'(ack), 32'd0);
    chk("mid_valida", 32'(saida_valida), 32'd0);
    chk("mid_saida", 32'(saida), 32'd0);
    chk("mid_total", 32'(total), 32'd0);
    chk("mid_ocupado", 32'(ocupado), 32'd0);
    rst = 1'b0;
    req = 4'b1111;
    tick();
    chk("mid_ptr0", 32'(ack), 32'd1);
    for (int i = 0; i < 12; i++) begin
      req = req & ~ack;
      tick();
    end

    // Exhaustive conversion and counter wrap, requester 0 only
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hs_count = 0;
    op = 0;
    req = 4'b0001;
    set_op(0, op);
    saida_pronta = 1'b1;
    guard = 0;
    while (hs_count < 255 && guard < 1000) begin
      tick();
      if (ack[0]) begin
        op = (op + 1) % 16;
        set_op(0, op);
      end
      guard++;
    end
    chk("wrap_255", 32'(total), 32'd255);
    while (hs_count < 256 && guard < 1000) begin
      tick();
      if (ack[0]) begin
        op = (op + 1) % 16;
        set_op(0, op);
      end
      guard++;
    end
    chk("wrap_0", 32'(total), 32'd0);
    chk("wrap_bound", 32'(guard < 1000), 32'd1);
    req = '0;
    for (int i = 0; i < 4; i++) tick();

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      logic [N-1:0] a;
      a = ack;
      for (int i = 0; i < N; i++) begin
        if (a[i]) begin
          req[i] = 1'($urandom % 2);
          if (req[i]) set_op(i, int'($urandom % 16));
        end else if (!req[i] && ($urandom % 4 == 0)) begin
          req[i] = 1'b1;
          set_op(i, int'($urandom % 16));
        end
      end
      saida_pronta = ($urandom % 3 != 0);
      rst = ($urandom % 300 == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
